// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 message-schedule slice:
//   WORD_W        - the only legal word width (SHA-224/256 operate on 32-bit words)
//   sched_state_t - schedule-buffer control states
//   ssig0/ssig1   - the "small sigma" mixing functions used to extend the schedule
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } sched_state_t;

    // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// sha256_w_next
// Combinational next-word generator for the SHA-256 message schedule:
//   w16 = ssig1(w14) + w9 + ssig0(w1) + w0   (mod 2^32)
// Ports:
//   w14, w9, w1, w0 : in  window taps W_{t-2}, W_{t-7}, W_{t-15}, W_{t-16}
//   w16             : out new schedule word W_t
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w14,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w0,
    output logic [WORD_W-1:0] w16
);

    // The sum is truncated to WORD_W bits, which gives the modulo-2^32 wrap.
    assign w16 = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// SHA-256 message-schedule buffer. Loads one 16-word message block into a
// sliding window, then streams W_0..W_{ROUNDS-1} to the round engine.
// Ports:
//   CLK, RST            : clock (rising edge), asynchronous active-low reset
//   start               : begin a new block (only honoured in IDLE)
//   abort               : synchronous return to IDLE, beats everything but RST
//   in_valid/in_ready   : message word handshake, in_word carries M_0 first
//   w_valid/w_ready     : schedule word handshake, w_out = W_t, w_idx = t
//   busy                : high while loading or expanding
//   done                : one-cycle pulse after W_{ROUNDS-1} is accepted
module sha256_msg_schedule #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int ROUNDS      = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        w_idx,
    output logic              busy,
    output logic              done
);

    import sha256_pkg::*;

    // The expansion taps and sigma functions only make sense for the
    // SHA-256 geometry, so anything else is refused at elaboration.
    if (WORD_W != 32) begin : g_bad_word_w
        $error("sha256_msg_schedule: WORD_W must be 32");
    end
    if (BLOCK_WORDS != 16) begin : g_bad_block_words
        $error("sha256_msg_schedule: BLOCK_WORDS must be 16");
    end
    if (ROUNDS < 17 || ROUNDS > 64) begin : g_bad_rounds
        $error("sha256_msg_schedule: ROUNDS must be in 17..64");
    end

    localparam logic [5:0] LAST_LOAD  = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [5:0]        counter;
    logic [WORD_W-1:0] win [BLOCK_WORDS];
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] shift_word;
    logic              in_acc;
    logic              w_acc;
    logic              shift_en;
    logic              last_load;
    logic              last_round;

    assign in_acc     = in_valid && in_ready;
    assign w_acc      = w_valid && w_ready;
    assign last_load  = (counter == LAST_LOAD);
    assign last_round = (counter == LAST_ROUND);

    // Next schedule word computed from the current window taps.
    sha256_w_next u_w_next (
        .w14 (win[BLOCK_WORDS-2]),
        .w9  (win[BLOCK_WORDS-7]),
        .w1  (win[1]),
        .w0  (win[0]),
        .w16 (w_new)
    );

    // State register. Reset drops straight back to IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. abort is applied last so it
    // overrides any transition, including a start seen in IDLE.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        w_valid  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_load) begin
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                if (w_ready && last_round) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Word counter: counts accepted inputs in LOAD and emitted words in
    // EXPAND. In EXPAND it holds at the terminal index rather than wrapping.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            counter <= '0;
        end else if (abort) begin
            counter <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_acc) begin
                        counter <= last_load ? 6'd0 : counter + 6'd1;
                    end
                end
                EXPAND: begin
                    if (w_acc && !last_round) begin
                        counter <= counter + 6'd1;
                    end
                end
                default: counter <= '0;
            endcase
        end
    end

    // Sliding window: every accepted word (message word in LOAD, new
    // schedule word in EXPAND) enters at the top and win[0] falls off.
    // An abort leaves the contents alone; the next LOAD refills all of it.
    assign shift_en   = (in_acc || w_acc) && !abort;
    assign shift_word = in_acc ? in_word : w_new;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                win[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[BLOCK_WORDS-1] <= shift_word;
        end
    end

    // done fires in the cycle after the final schedule word is taken,
    // unless that same cycle was aborted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done <= 1'b0;
        end else begin
            done <= w_acc && last_round && !abort;
        end
    end

    assign w_out = w_valid ? win[0] : '0;
    assign w_idx = w_valid ? counter : 6'd0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule
// Self-checking bench for sha256_msg_schedule. A reference schedule is built
// from the standard W_t recurrence over a whole block; a compare process
// checks every emitted word, its index and the done pulse against it.
module tb_sha256_msg_schedule;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_out;
    logic [5:0]  w_idx;
    logic        busy;
    logic        done;

    int     n_checks   = 0;
    int     n_fail     = 0;
    int     exp_idx    = 0;
    int     done_count = 0;
    bit     done_due   = 0;
    sched_t exp_w;

    sha256_msg_schedule #(
        .WORD_W      (32),
        .BLOCK_WORDS (16),
        .ROUNDS      (64)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: plain rotate/shift arithmetic over the whole block.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic sched_t model_schedule(input blk_t m);
        sched_t w;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++) w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Compare process: every cycle, the offered word/index must match the
    // model at the next expected position, and done must pulse exactly once
    // after W_63 is taken (never after an abort or reset).
    always @(negedge CLK) begin
        if (!RST) begin
            exp_idx  = 0;
            done_due = 0;
        end else begin
            checkOutput("done", 32'(done), 32'(done_due));
            if (done) done_count++;
            done_due = 0;
            if (w_valid) begin
                if (exp_idx < 64) begin
                    checkOutput("w_out", w_out, exp_w[exp_idx]);
                    checkOutput("w_idx", 32'(w_idx), 32'(exp_idx));
                end else begin
                    checkOutput("extra_w_valid", 32'(w_valid), 32'd0);
                end
                if (w_ready && !abort) begin
                    if (exp_idx == 63) begin
                        done_due = 1;
                        exp_idx  = 0;
                    end else begin
                        exp_idx++;
                    end
                end
            end
            if (abort) begin
                exp_idx  = 0;
                done_due = 0;
            end
        end
    end

    // Load one block. Optionally issues start first; gap mode randomises
    // in_valid, pulses a stray start mid-load and leaves in_valid high into
    // EXPAND to show both are ignored.
    task automatic applyStimulus(input blk_t m, input bit do_start, input bit gaps);
        int k;
        k = 0;
        @(posedge CLK); #1;
        if (do_start) begin
            start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        for (int cyc = 0; cyc < 200 && k < 16; cyc++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_word  = m[k];
            start    = (gaps && cyc == 2);
            @(negedge CLK);
            if (in_valid && in_ready) k++;
            @(posedge CLK); #1;
        end
        start    = 1'b0;
        in_valid = gaps;
        in_word  = $urandom;
        checkOutput("load_accepts", 32'(k), 32'd16);
        @(negedge CLK);
        checkOutput("w0_latency_valid", 32'(w_valid), 32'd1);
        checkOutput("in_ready_in_expand", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    // Drain the schedule with optional random back-pressure, a 3-cycle stall
    // at one index, an abort at one index and a stray start pulse.
    task automatic runExpand(input bit rand_ready, input int stall_at, input int abort_at,
                             input int start_at, output bit got_done, output bit got_abort);
        int stall_cnt;
        bit stalling;
        got_done  = 0;
        got_abort = 0;
        stall_cnt = 0;
        @(posedge CLK); #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            stalling = 0;
            abort    = 1'b0;
            start    = (cyc == start_at);
            if (abort_at >= 0 && w_valid && int'(w_idx) == abort_at) begin
                abort     = 1'b1;
                w_ready   = 1'($urandom_range(0, 1));
                got_abort = 1;
            end else if (stall_at >= 0 && w_valid && int'(w_idx) == stall_at && stall_cnt < 3) begin
                w_ready  = 1'b0;
                stall_cnt++;
                stalling = 1;
            end else begin
                w_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge CLK);
            if (stalling) checkOutput("stall_w_idx", 32'(w_idx), 32'(stall_at));
            if (done || got_abort) begin
                got_done = done;
                break;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
        if (stall_at >= 0) checkOutput("stall_cycles", 32'(stall_cnt), 32'd3);
    endtask

    initial begin : main
        blk_t   m;
        sched_t ref_s;
        bit     got_done;
        bit     got_abort;

        RST      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        w_ready  = 1'b0;

        // Reset values
        repeat (2) @(negedge CLK);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_w_valid", 32'(w_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_w_out", w_out, 32'd0);
        checkOutput("rst_w_idx", 32'(w_idx), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // "abc" block: pin the model with hand-computed words, then run it
        // with a stall at t=20, a stray start in EXPAND and a start in the
        // done cycle.
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        ref_s = model_schedule(m);
        checkOutput("model_W0", ref_s[0], 32'h61626380);
        checkOutput("model_W15", ref_s[15], 32'h00000018);
        checkOutput("model_W16", ref_s[16], 32'h61626380);
        checkOutput("model_W17", ref_s[17], 32'h000F0000);
        exp_w = ref_s;
        $display("[TB] abc block");
        applyStimulus(m, 1'b1, 1'b0);
        runExpand(1'b0, 20, -1, 40, got_done, got_abort);
        checkOutput("abc_done", 32'(got_done), 32'd1);
        start = 1'b1;
        @(posedge CLK); #1;
        start   = 1'b0;
        w_ready = 1'b0;
        @(negedge CLK);
        checkOutput("start_in_done_cycle", 32'(in_ready), 32'd1);

        // Random block with input gaps, already in LOAD
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp_w = model_schedule(m);
        $display("[TB] random block with input gaps");
        applyStimulus(m, 1'b0, 1'b1);
        runExpand(1'b1, -1, -1, -1, got_done, got_abort);
        checkOutput("gaps_done", 32'(got_done), 32'd1);
        w_ready = 1'b0;

        // Abort at t=30, then abort+start together
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp_w = model_schedule(m);
        $display("[TB] abort at t=30");
        applyStimulus(m, 1'b1, 1'b0);
        runExpand(1'b1, -1, 30, -1, got_done, got_abort);
        checkOutput("abort_seen", 32'(got_abort), 32'd1);
        @(posedge CLK); #1;
        abort   = 1'b0;
        w_ready = 1'b0;
        @(negedge CLK);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_w_valid", 32'(w_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        checkOutput("abort_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge CLK);

        // Fresh block after the abort
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp_w = model_schedule(m);
        $display("[TB] block after abort");
        applyStimulus(m, 1'b1, 1'b0);
        runExpand(1'b1, -1, -1, -1, got_done, got_abort);
        checkOutput("post_abort_done", 32'(got_done), 32'd1);
        w_ready = 1'b0;

        // Reset in the middle of EXPAND
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp_w = model_schedule(m);
        $display("[TB] reset mid-expand");
        applyStimulus(m, 1'b1, 1'b0);
        @(posedge CLK); #1;
        w_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checkOutput("midrst_w_valid", 32'(w_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_w_out", w_out, 32'd0);
        checkOutput("midrst_w_idx", 32'(w_idx), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        w_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 16; i++) m[i] = $urandom;
        exp_w = model_schedule(m);
        $display("[TB] block after reset");
        applyStimulus(m, 1'b1, 1'b0);
        runExpand(1'b1, -1, -1, -1, got_done, got_abort);
        checkOutput("post_rst_done", 32'(got_done), 32'd1);
        w_ready = 1'b0;
        repeat (3) @(negedge CLK);

        checkOutput("done_pulse_count", 32'(done_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
